if_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage; successor to the single-register IF stage.

---
 rtl/if_prefetch_queue.sv | 133 +++++++++++++
 tb/tb_if_prefetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Purpose  : Instruction fetch stage with a DEPTH-entry in-order prefetch queue
//            between a valid/ready instruction memory and the IF/ID boundary.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            ifid_valid,
    input  logic            ifid_ready,
    output logic [31:0]     ifid_inst,
    output logic [XLEN-1:0] ifid_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(2 * DEPTH) + 1;
    localparam logic [AW:0]     PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [DW-1:0]   DROP_ONE = DW'(1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    // Entries [head, pend) are FILLED, [pend, tail) are PENDING; the extra
    // pointer bit distinguishes a full queue from an empty one.
    logic [AW:0]     head_q, head_d;
    logic [AW:0]     pend_q, pend_d;
    logic [AW:0]     tail_q, tail_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];

    logic [AW:0]     occupancy;
    logic [AW:0]     pend_cnt;
    logic            head_filled;
    logic            req_fire;
    logic            deq;
    logic [DW-1:0]   drop_sum;
    logic            unused_redirect_lsbs;

    assign occupancy   = tail_q - head_q;
    assign pend_cnt    = tail_q - pend_q;
    assign head_filled = (head_q != pend_q);

    assign imem_req_valid = rstb && (occupancy < OCC_FULL) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign deq            = head_filled && ifid_ready && !redirect_valid;

    assign ifid_valid = head_filled;
    assign ifid_inst  = head_filled ? inst_q[head_q[AW-1:0]] : 32'h0;
    assign ifid_pc    = head_filled ? pc_q[head_q[AW-1:0]]   : '0;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        head_d     = head_q;
        pend_d     = pend_q;
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        drop_sum   = drop_cnt_q + DW'(pend_cnt);

        if (redirect_valid) begin
            // Every outstanding PENDING request turns into a response to discard.
            head_d     = tail_q;
            pend_d     = tail_q;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_cnt_d = drop_sum - DROP_ONE;
            end else begin
                drop_cnt_d = drop_sum;
            end
        end else begin
            if (req_fire) begin
                pc_d[tail_q[AW-1:0]] = fetch_pc_q;
                tail_d               = tail_q + PTR_ONE;
                fetch_pc_d           = fetch_pc_q + PC_STEP;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - DROP_ONE;
                end else if (pend_q != tail_q) begin
                    inst_d[pend_q[AW-1:0]] = imem_rsp_data;
                    pend_d                 = pend_q + PTR_ONE;
                end
            end
            if (deq) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            head_q     <= '0;
            pend_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            pend_q     <= pend_d;
            tail_q     <= tail_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// Testbench for if_prefetch_queue: directed vector table, reset-mid-burst
// sequence, then randomized traffic against a golden PC-stream model.
`timescale 1ns/1ps
module tb_if_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          NVEC     = 19;
    localparam int          NRAND    = 3000;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ifid_valid;
    logic        ifid_ready = 1'b0;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;

    always #5 clk = ~clk;

    if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstb(rstb),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic        rdy, rsp, ifr, redir;
        logic [31:0] rsp_pc, redir_pc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] rsp_pc,
                                input logic ifr, input logic redir, input logic [31:0] redir_pc,
                                input logic e_rv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.rsp_pc = rsp_pc; v.ifr = ifr;
        v.redir = redir; v.redir_pc = redir_pc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    vec_t        tbl[NVEC];
    logic [31:0] exp_pc, exp_req, e_inst;
    int          cyc, last_due, consumed;

    initial begin
        // Fill to DEPTH under stall, drain, redirect with 3 PENDING + same-cycle rsp,
        // two dropped responses, then unaligned redirect.
        tbl[0]  = mk(1, 0, 0,       0, 0, 0,       1, 32'h000, 0, 0);
        tbl[1]  = mk(1, 1, 32'h000, 0, 0, 0,       1, 32'h004, 0, 0);
        tbl[2]  = mk(1, 1, 32'h004, 0, 0, 0,       1, 32'h008, 1, 32'h000);
        tbl[3]  = mk(1, 1, 32'h008, 0, 0, 0,       1, 32'h00C, 1, 32'h000);
        tbl[4]  = mk(1, 1, 32'h00C, 0, 0, 0,       0, 32'h010, 1, 32'h000);
        tbl[5]  = mk(1, 0, 0,       0, 0, 0,       0, 32'h010, 1, 32'h000);
        tbl[6]  = mk(1, 0, 0,       1, 0, 0,       0, 32'h010, 1, 32'h000);
        tbl[7]  = mk(1, 0, 0,       1, 0, 0,       1, 32'h010, 1, 32'h004);
        tbl[8]  = mk(1, 0, 0,       1, 0, 0,       1, 32'h014, 1, 32'h008);
        tbl[9]  = mk(1, 0, 0,       1, 0, 0,       1, 32'h018, 1, 32'h00C);
        tbl[10] = mk(1, 1, 32'h010, 1, 1, 32'h100, 0, 32'h01C, 0, 0);
        tbl[11] = mk(1, 1, 32'h014, 1, 0, 0,       1, 32'h100, 0, 0);
        tbl[12] = mk(0, 1, 32'h018, 1, 0, 0,       1, 32'h104, 0, 0);
        tbl[13] = mk(0, 1, 32'h100, 1, 0, 0,       1, 32'h104, 0, 0);
        tbl[14] = mk(0, 0, 0,       1, 0, 0,       1, 32'h104, 1, 32'h100);
        tbl[15] = mk(1, 0, 0,       1, 1, 32'h203, 0, 32'h104, 0, 0);
        tbl[16] = mk(1, 0, 0,       1, 0, 0,       1, 32'h200, 0, 0);
        tbl[17] = mk(0, 1, 32'h200, 0, 0, 0,       1, 32'h204, 0, 0);
        tbl[18] = mk(0, 0, 0,       0, 0, 0,       1, 32'h204, 1, 32'h200);

        #2;
        check("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("reset_req_addr", imem_req_addr, RESET_PC);
        check("reset_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        check("reset_ifid_pc", ifid_pc, 32'h0);
        check("reset_ifid_inst", ifid_inst, 32'h0);
        #15 rstb = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsp;
            imem_rsp_data  = inst_of(tbl[i].rsp_pc);
            ifid_ready     = tbl[i].ifr;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].redir_pc;
            #1;
            e_inst = tbl[i].e_iv ? inst_of(tbl[i].e_pc) : 32'h0;
            check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            check($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_ifid_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_iv});
            check($sformatf("vec%0d_ifid_pc", i), ifid_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_ifid_inst", i), ifid_inst, e_inst);
            @(posedge clk); #1;
        end

        // Two more accepts with no responses, then async reset mid-cycle.
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; ifid_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        imem_req_ready = 1'b0;
        #1;
        check("burst_req_addr", imem_req_addr, 32'h20C);
        check("burst_ifid_pc", ifid_pc, 32'h200);
        rstb = 1'b0;
        #1;
        check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("async_rst_req_addr", imem_req_addr, RESET_PC);
        check("async_rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        check("async_rst_ifid_pc", ifid_pc, 32'h0);
        check("async_rst_ifid_inst", ifid_inst, 32'h0);
        @(posedge clk); #2;
        rstb = 1'b1;
        #1;
        check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("post_rst_req_addr", imem_req_addr, RESET_PC);
        check("post_rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic: golden model tracks the next PC ID must see and the
        // next address fetch must issue; memory answers in order after 1-5 cycles.
        exp_pc = RESET_PC; exp_req = RESET_PC;
        cyc = 0; last_due = 0; consumed = 0;
        mq.delete();
        for (int n = 0; n < NRAND; n++) begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            ifid_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 49) == 0);
            redirect_pc    = $urandom & 32'h0000_0FFF;
            #1;
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                req_t r;
                int   d;
                check("rand_req_addr", imem_req_addr, exp_req);
                d = cyc + $urandom_range(1, 5);
                if (d < last_due) d = last_due;
                last_due = d;
                r.addr = imem_req_addr;
                r.due  = d;
                mq.push_back(r);
                exp_req = exp_req + 32'd4;
            end
            if (ifid_valid) check("rand_inst_matches_pc", ifid_inst, inst_of(ifid_pc));
            if (redirect_valid) begin
                check("rand_redirect_blocks_req", {31'b0, imem_req_valid}, 32'h0);
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end else if (ifid_valid && ifid_ready) begin
                check("rand_ifid_pc_order", ifid_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (consumed < 300) begin
            miscompares++;
            $display("FAIL rand_throughput: got %0d instructions, expected at least 300", consumed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
